demux16_stream: RTL and testbench



---
 rtl/demux16_pkg.sv | 11 +
 rtl/stream_fifo.sv | 42 ++++
 rtl/demux16_stream.sv | 101 ++++++++++
 tb/tb_demux16_stream.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux16_pkg.sv
// Shared constants for the 1-to-2 stream demultiplexer.
package demux16_pkg;

  localparam int N_DEF     = 16;
  localparam int DEPTH_DEF = 2;
  localparam int CNT_W_DEF = 16;

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

endpackage

// File: rtl/stream_fifo.sv
// First-word-fall-through synchronous FIFO; head_data is valid whenever empty=0.
module stream_fifo #(
  parameter int N     = 16,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [N-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [N-1:0] head_data
);

  localparam int AW = $clog2(DEPTH);

  // Extra MSB on each pointer separates the full and empty cases.
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [N-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/demux16_stream.sv
// Registered 1-to-2 stream demux: explicit or round-robin steering into two
// per-lane FIFOs, with saturating delivered-word counters per lane.
module demux16_stream
  import demux16_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             alt_mode,
  input  logic             clr_cnt,
  output logic [N-1:0]     out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [N-1:0]     out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  logic         toggle;
  logic         tgt;
  logic         accept;
  logic         push0, push1;
  logic         pop0, pop1;
  logic         full0, full1;
  logic         empty0, empty1;
  logic [N-1:0] head0, head1;

  // in_ready looks only at the registered full flags, never at outX_ready.
  always_comb begin
    tgt      = alt_mode ? toggle : in_sel;
    in_ready = rst_n && !((tgt == LANE1) ? full1 : full0);
  end

  assign accept = in_valid && in_ready;
  assign push0  = accept && (tgt == LANE0);
  assign push1  = accept && (tgt == LANE1);

  stream_fifo #(.N(N), .DEPTH(DEPTH)) u_fifo0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push0),
    .push_data (in_data),
    .pop       (pop0),
    .full      (full0),
    .empty     (empty0),
    .head_data (head0)
  );

  stream_fifo #(.N(N), .DEPTH(DEPTH)) u_fifo1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push1),
    .push_data (in_data),
    .pop       (pop1),
    .full      (full1),
    .empty     (empty1),
    .head_data (head1)
  );

  assign out0_valid = !empty0;
  assign out1_valid = !empty1;
  assign out0_data  = out0_valid ? head0 : '0;
  assign out1_data  = out1_valid ? head1 : '0;
  assign pop0       = out0_valid && out0_ready;
  assign pop1       = out1_valid && out1_ready;

  // Held at lane 0 outside alt_mode so each round-robin session starts on lane 0.
  always_ff @(posedge clk) begin
    if (!rst_n || !alt_mode) begin
      toggle <= LANE0;
    end else if (accept) begin
      toggle <= ~toggle;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr_cnt) begin
      cnt0 <= '0;
    end else if (pop0 && (cnt0 != '1)) begin
      cnt0 <= cnt0 + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr_cnt) begin
      cnt1 <= '0;
    end else if (pop1 && (cnt1 != '1)) begin
      cnt1 <= cnt1 + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_demux16_stream.sv
// Self-checking bench for demux16_stream against a queue-based reference model.
module tb_demux16_stream;

  localparam int N     = 16;
  localparam int DEPTH = 2;
  localparam int CNT_W = 10;
  localparam int VW    = 3 + 2*N + 2*CNT_W;
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic             alt_mode;
  logic             clr_cnt;
  logic [N-1:0]     out0_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [N-1:0]     out1_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  demux16_stream #(.N(N), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alt_mode   (alt_mode),
    .clr_cnt    (clr_cnt),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: one queue per lane plus counters and the round-robin pointer.
  logic [N-1:0]     q0[$], q1[$];
  logic [N-1:0]     log0[$], log1[$];
  logic             m_toggle;
  logic [CNT_W-1:0] m_cnt0, m_cnt1;
  logic [VW-1:0]    last_obs, last_exp;

  function automatic logic [VW-1:0] exp_vec();
    logic         tgt, rdy;
    logic [N-1:0] h0, h1;
    tgt = alt_mode ? m_toggle : in_sel;
    rdy = rst_n && ((tgt ? q1.size() : q0.size()) < DEPTH);
    h0  = (q0.size() != 0) ? q0[0] : '0;
    h1  = (q1.size() != 0) ? q1[0] : '0;
    return {rdy, q0.size() != 0, h0, q1.size() != 0, h1, m_cnt0, m_cnt1};
  endfunction

  task automatic model_edge();
    logic tgt, acc, p0, p1;
    if (!rst_n) begin
      q0.delete(); q1.delete();
      m_toggle = 1'b0; m_cnt0 = '0; m_cnt1 = '0;
      return;
    end
    tgt = alt_mode ? m_toggle : in_sel;
    acc = in_valid && ((tgt ? q1.size() : q0.size()) < DEPTH);
    p0  = (q0.size() != 0) && out0_ready;
    p1  = (q1.size() != 0) && out1_ready;
    if (p0) void'(q0.pop_front());
    if (p1) void'(q1.pop_front());
    if (clr_cnt) begin m_cnt0 = '0; m_cnt1 = '0; end
    else begin
      if (p0 && m_cnt0 != CMAX) m_cnt0 = m_cnt0 + 1'b1;
      if (p1 && m_cnt1 != CMAX) m_cnt1 = m_cnt1 + 1'b1;
    end
    if (acc) begin
      if (tgt) q1.push_back(in_data);
      else     q0.push_back(in_data);
    end
    if (!alt_mode) m_toggle = 1'b0;
    else if (acc)  m_toggle = ~m_toggle;
  endtask

  // Sample DUT and model at the falling edge, then advance the model at the rising edge.
  task automatic step();
    @(negedge clk);
    last_obs = {in_ready, out0_valid, out0_data, out1_valid, out1_data, cnt0, cnt1};
    last_exp = exp_vec();
    if (rst_n && out0_valid && out0_ready) log0.push_back(out0_data);
    if (rst_n && out1_valid && out1_ready) log1.push_back(out1_data);
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
  endtask

  task automatic drive(input logic v, input logic s, input logic a, input logic [N-1:0] d);
    in_valid = v; in_sel = s; alt_mode = a; in_data = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr_cnt = 1'b0; out0_ready = 1'b0; out1_ready = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0);
    step();
    step();
    n_checks++;
    if (last_obs !== '0) begin
      n_fail++; $display("FAIL reset_state got=%h exp=%h", last_obs, {VW{1'b0}});
    end
    rst_n = 1'b1;
    step();
    n_checks++;
    if (last_obs !== last_exp || last_obs[VW-1] !== 1'b1) begin
      n_fail++; $display("FAIL reset_release got=%h exp=%h", last_obs, last_exp);
    end
  endtask

  task automatic test_explicit();
    logic [N-1:0] wd [3] = '{16'h1111, 16'h2222, 16'h3333};
    logic         sd [3] = '{1'b0, 1'b1, 1'b0};
    logic [N-1:0] e0[$], e1[$];
    logic         ok;
    log0.delete(); log1.delete();
    out0_ready = 1'b1; out1_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 3) drive(1'b1, sd[i], 1'b0, wd[i]);
      else       drive(1'b0, 1'b0, 1'b0, 16'hDEAD);
      step();
      n_checks++;
      if (last_obs !== last_exp) begin
        n_fail++; $display("FAIL explicit_cycle cyc=%0d got=%h exp=%h", cyc, last_obs, last_exp);
      end
    end
    e0 = {16'h1111, 16'h3333};
    e1 = {16'h2222};
    ok = (log0.size() == e0.size()) && (log1.size() == e1.size());
    foreach (e0[i]) if (ok && log0[i] !== e0[i]) ok = 1'b0;
    foreach (e1[i]) if (ok && log1[i] !== e1[i]) ok = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL explicit_order got lane0=%0d lane1=%0d words, exp 2 and 1 in order", log0.size(), log1.size());
    end
    n_checks++;
    if (cnt0 !== CNT_W'(2) || cnt1 !== CNT_W'(1)) begin
      n_fail++; $display("FAIL explicit_counts got cnt0=%0d cnt1=%0d exp 2 1", cnt0, cnt1);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] e0[$], e1[$];
    logic         ok;
    log0.delete(); log1.delete();
    out0_ready = 1'b1; out1_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      if (i < 7)       drive(1'b1, 1'b1, 1'b1, 16'hA000 + N'(i));
      else if (i == 7) drive(1'b1, 1'b1, 1'b0, 16'hB000);
      else if (i == 8) drive(1'b1, 1'b1, 1'b1, 16'hB001);
      else             drive(1'b0, 1'b0, 1'b1, 16'h0);
      step();
      n_checks++;
      if (last_obs !== last_exp) begin
        n_fail++; $display("FAIL rr_cycle cyc=%0d got=%h exp=%h", cyc, last_obs, last_exp);
      end
    end
    e0 = {16'hA000, 16'hA002, 16'hA004, 16'hA006, 16'hB001};
    e1 = {16'hA001, 16'hA003, 16'hA005, 16'hB000};
    ok = (log0.size() == e0.size()) && (log1.size() == e1.size());
    foreach (e0[i]) if (ok && log0[i] !== e0[i]) ok = 1'b0;
    foreach (e1[i]) if (ok && log1[i] !== e1[i]) ok = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL rr_order got lane0=%0d lane1=%0d words, exp 5 and 4 in order", log0.size(), log1.size());
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] w [2];
    logic         ok;
    log0.delete(); log1.delete();
    out0_ready = 1'b0; out1_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      w[i] = N'($urandom);
      drive(1'b1, 1'b0, 1'b0, w[i]);
      step();
    end
    drive(1'b1, 1'b0, 1'b0, 16'hBAD0);
    step();
    n_checks++;
    if (last_obs[VW-1] !== 1'b0 || last_obs !== last_exp) begin
      n_fail++; $display("FAIL bp_lane0_full got=%h exp=%h", last_obs, last_exp);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, N'($urandom));
      step();
      n_checks++;
      if (last_obs[VW-1] !== 1'b1 || last_obs !== last_exp) begin
        n_fail++; $display("FAIL bp_lane1_flow cyc=%0d got=%h exp=%h", cyc, last_obs, last_exp);
      end
    end
    out0_ready = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (last_obs !== last_exp) begin
        n_fail++; $display("FAIL bp_drain cyc=%0d got=%h exp=%h", cyc, last_obs, last_exp);
      end
    end
    ok = (log0.size() == 2) && (log1.size() == 3);
    if (ok) ok = (log0[0] === w[0]) && (log0[1] === w[1]);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL bp_order got lane0=%0d lane1=%0d words, exp 2 (%h,%h) and 3", log0.size(), log1.size(), w[0], w[1]);
    end
  endtask

  task automatic test_full_pop();
    logic [N-1:0] f [3];
    logic         ok;
    log0.delete(); log1.delete();
    out0_ready = 1'b0; out1_ready = 1'b1;
    for (int i = 0; i < 3; i++) f[i] = 16'hF000 + N'(i);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b0, f[i]);
      step();
    end
    out0_ready = 1'b1;
    drive(1'b1, 1'b0, 1'b0, f[2]);
    step();
    n_checks++;
    if (last_obs[VW-1] !== 1'b0 || last_obs !== last_exp) begin
      n_fail++; $display("FAIL fullpop_no_accept got=%h exp=%h", last_obs, last_exp);
    end
    step();
    n_checks++;
    if (last_obs[VW-1] !== 1'b1 || last_obs !== last_exp) begin
      n_fail++; $display("FAIL fullpop_accept got=%h exp=%h", last_obs, last_exp);
    end
    drive(1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) step();
    ok = (log0.size() == 3);
    for (int i = 0; i < 3; i++) if (ok && log0[i] !== f[i]) ok = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL fullpop_order got %0d lane0 words exp 3 (F000,F001,F002)", log0.size());
    end
  endtask

  task automatic test_counters();
    out0_ready = 1'b1; out1_ready = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0);
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    for (int i = 0; i < int'(CMAX) - 1; i++) begin
      drive(1'b1, 1'b0, 1'b0, N'(i));
      step();
      n_checks++;
      if (last_obs !== last_exp) begin
        n_fail++; $display("FAIL cnt_stream cyc=%0d got=%h exp=%h", cyc, last_obs, last_exp);
      end
    end
    drive(1'b0, 1'b0, 1'b0, '0);
    step(); step();
    n_checks++;
    if (cnt0 !== CMAX - 1'b1) begin
      n_fail++; $display("FAIL cnt_near_max got=%0d exp=%0d", cnt0, CMAX - 1'b1);
    end
    for (int i = 0; i < 5; i++) begin
      drive(i < 3, 1'b0, 1'b0, 16'hC0DE);
      step();
    end
    n_checks++;
    if (cnt0 !== CMAX) begin
      n_fail++; $display("FAIL cnt_saturate got=%0d exp=%0d", cnt0, CMAX);
    end
    drive(1'b1, 1'b0, 1'b0, 16'h5A5A);
    step();
    drive(1'b0, 1'b0, 1'b0, '0);
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    n_checks++;
    if (last_obs[VW-2] !== 1'b1 || cnt0 !== '0) begin
      n_fail++; $display("FAIL cnt_clr_priority got valid=%b cnt0=%0d exp valid=1 cnt0=0", last_obs[VW-2], cnt0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 2) == 0, N'($urandom));
      out0_ready = $urandom_range(0, 3) != 0;
      out1_ready = $urandom_range(0, 1) != 0;
      clr_cnt    = $urandom_range(0, 63) == 0;
      step();
      n_checks++;
      if (last_obs !== last_exp) begin
        n_fail++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, last_obs, last_exp);
      end
    end
    clr_cnt = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic ok;
    out0_ready = 1'b0; out1_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, i >= 2, 1'b0, 16'hE000 + N'(i));
      step();
    end
    drive(1'b0, 1'b0, 1'b1, '0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({in_ready, out0_valid, out0_data, out1_valid, out1_data, cnt0, cnt1} !== {1'b1, {(VW-1){1'b0}}}) begin
      n_fail++; $display("FAIL reset_mid got=%h exp=%h", {in_ready, out0_valid, out0_data, out1_valid, out1_data, cnt0, cnt1}, {1'b1, {(VW-1){1'b0}}});
    end
    @(posedge clk); #1;
    log0.delete(); log1.delete();
    out0_ready = 1'b1; out1_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(i < 4, 1'b1, 1'b1, 16'hC000 + N'(i));
      step();
      n_checks++;
      if (last_obs !== last_exp) begin
        n_fail++; $display("FAIL reset_mid_traffic cyc=%0d got=%h exp=%h", cyc, last_obs, last_exp);
      end
    end
    ok = (log0.size() == 2) && (log1.size() == 2);
    if (ok) ok = (log0[0] === 16'hC000) && (log0[1] === 16'hC002) && (log1[0] === 16'hC001) && (log1[1] === 16'hC003);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL reset_mid_order got lane0=%0d lane1=%0d words, exp C000,C002 / C001,C003", log0.size(), log1.size());
    end
  endtask

  initial begin
    m_toggle = 1'b0; m_cnt0 = '0; m_cnt1 = '0;
    test_reset();
    test_explicit();
    test_round_robin();
    test_backpressure();
    test_full_pop();
    test_counters();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
